// File: rtl/dictmem_arbiter_if.sv
// Request/response bundle shared by the two dictionary readers and the arbiter.
interface dictmem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) ();
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic              req1_ready;
  logic              rsp0_valid;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output req0_valid, req0_addr, req1_valid, req1_addr,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data
  );

  modport slave (
    input  req0_valid, req0_addr, req1_valid, req1_addr,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data
  );
endinterface

// File: rtl/dictmem_arbiter.sv
// Two-requester arbiter in front of a one-cycle-latency dictionary ROM.
// Define DICTMEM_ARBITER_FIXED_PRIO_EN for strict requester-0 priority instead of round-robin.
module dictmem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  dictmem_arbiter_if.slave  bus,
  output logic [ADDR_W-1:0] address_dictmem,
  input  logic [DATA_W-1:0] q_dictmem,
  output logic [15:0]       gnt0_count,
  output logic [15:0]       gnt1_count
);
  logic       pick1;
  logic [1:0] grant;
  logic       rsp_valid_reg;
  logic       rsp_id_reg;

`ifdef DICTMEM_ARBITER_FIXED_PRIO_EN
  assign pick1 = bus.req1_valid && !bus.req0_valid;
`else
  // last_grant_reg = 1 means requester 1 won most recently, so a tie goes to 0.
  logic last_grant_reg;

  assign pick1 = bus.req1_valid && (!bus.req0_valid || !last_grant_reg);

  always_ff @(posedge clock) begin
    if (reset)
      last_grant_reg <= 1'b1;
    else if (grant != 2'b00)
      last_grant_reg <= grant[1];
  end
`endif

  assign grant[0] = !reset && bus.req0_valid && !pick1;
  assign grant[1] = !reset && pick1;

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];

  always_comb begin
    address_dictmem = '0;
    if (grant[0])
      address_dictmem = bus.req0_addr;
    else if (grant[1])
      address_dictmem = bus.req1_addr;
  end

  // The tag travels alongside the ROM read so the data lands on the right requester.
  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= 1'b0;
    end else begin
      rsp_valid_reg <= grant[0] || grant[1];
      rsp_id_reg    <= grant[1];
    end
  end

  assign bus.rsp0_valid = rsp_valid_reg && !rsp_id_reg;
  assign bus.rsp1_valid = rsp_valid_reg && rsp_id_reg;
  assign bus.rsp_data   = q_dictmem;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      logic [15:0] cnt_reg;

      always_ff @(posedge clock) begin
        if (reset)
          cnt_reg <= '0;
        else if (grant[gi] && cnt_reg != 16'hFFFF)
          cnt_reg <= cnt_reg + 16'd1;
      end
    end
  endgenerate

  assign gnt0_count = g_cnt[0].cnt_reg;
  assign gnt1_count = g_cnt[1].cnt_reg;
endmodule

// File: doc/dictmem_arbiter.md
DICTMEM_ARBITER -- requirements
Module: dictmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, dictionary word address width.
REQ-002 SHALL have parameter DATA_W, default 32, dictionary word width.
REQ-003 SHALL have port clock  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous active-high reset.
REQ-005 SHALL have port req0_valid  input  1  processor read request.
REQ-006 SHALL have port req0_addr  input  ADDR_W  processor read address.
REQ-007 SHALL have port req0_ready  output  1  processor request granted this cycle.
REQ-008 SHALL have port req1_valid  input  1  search-engine read request.
REQ-009 SHALL have port req1_addr  input  ADDR_W  search-engine read address.
REQ-010 SHALL have port req1_ready  output  1  search-engine request granted this cycle.
REQ-011 SHALL have port address_dictmem  output  ADDR_W  address to dictionary ROM.
REQ-012 SHALL have port q_dictmem  input  DATA_W  ROM read data, one cycle after address.
REQ-013 SHALL have port rsp0_valid  output  1  response for requester 0 on rsp_data.
REQ-014 SHALL have port rsp1_valid  output  1  response for requester 1 on rsp_data.
REQ-015 SHALL have port rsp_data  output  DATA_W  shared response data.
REQ-016 SHALL have ports gnt0_count, gnt1_count  output  16 each  saturating grant counters.

Function
REQ-017 SHALL grant at most one request per cycle; reqN_ready combinational from valids and arbitration state.
REQ-018 SHALL grant the sole valid requester when only one is valid.
REQ-019 SHALL, when both valid, grant the requester not granted most recently (round-robin via 1-bit last_grant register).
REQ-020 SHALL update last_grant only on a cycle with a grant; idle cycles leave it unchanged.
REQ-021 SHALL drive address_dictmem combinationally with the granted address; all zeros when no grant.
REQ-022 SHALL register a response tag (valid + requester id) on each grant; rspN_valid high exactly in the cycle after requester N's grant.
REQ-023 SHALL pass q_dictmem to rsp_data unmodified; rsp_data is don't-care when both rsp valids low.
REQ-024 SHALL sustain back-to-back grants: one response per cycle, in grant order, latency exactly 1 cycle.
REQ-025 SHALL never assert rsp0_valid and rsp1_valid in the same cycle.
REQ-026 SHALL increment gntN_count on each requester-N grant, saturating at 16'hFFFF (no wrap).
REQ-027 SHALL accept no response back-pressure; requesters capture rsp_data in the rspN_valid cycle.
REQ-028 SHALL treat a requester that drops valid before grant as withdrawn; no response issued.

Reset
REQ-029 SHALL, on reset high at a rising edge, set last_grant=1 (requester 0 wins first tie), response tag invalid, both counters 0.
REQ-030 SHALL force reqN_ready=0 and address_dictmem=0 combinationally while reset high.
REQ-031 SHALL drop any in-flight response when reset asserts mid-operation: rsp0_valid=rsp1_valid=0 in the cycle after the reset edge.
REQ-032 SHALL grant normally from the first rising edge after reset deasserts.

Configuration
REQ-033 SHALL, with macro DICTMEM_ARBITER_FIXED_PRIO_EN defined, give requester 0 strict priority on ties; last_grant unused and omitted.
REQ-034 SHALL, without DICTMEM_ARBITER_FIXED_PRIO_EN, use round-robin per REQ-019; all other behaviour identical in both builds.

Verification
REQ-035 SHALL cover: reset, then req0 alone addr 12'h005 -> req0_ready=1, address_dictmem=5, next cycle rsp0_valid=1, rsp_data=ROM[5], gnt0_count=1.
REQ-036 SHALL cover: both valid 4 consecutive cycles, addrs 10/20 -> grants 0,1,0,1; rsp_data ROM[10],ROM[20],ROM[10],ROM[20] on alternating rsp valids (fixed-prio build: four req0 grants, req1 starved).
REQ-037 SHALL cover: reset asserted the cycle after a req1 grant -> rsp1_valid=0 next cycle, gnt1_count=0, next tie after reset goes to requester 0.
REQ-038 SHALL cover: req1 alone held 65540 cycles -> gnt1_count=16'hFFFF, stays there, gnt0_count=0.
REQ-039 SHALL cover: req0 valid 1 cycle while req1 wins the tie, then req0 drops -> no rsp0_valid, gnt0_count unchanged.
